mips_fetch_unit: RTL
====================

# mips_fetch_unit

Parametrised, decoupled instruction-fetch stage for the multi-cycle and pipelined MIPS cores. It owns the PC, issues requests to a variable-latency instruction memory over a valid/ready handshake, and buffers returned instructions in a small flushable FIFO toward decode. It also computes next-PC for branch, jump and jump-register redirects. The jump target is `{pc4[31:28], target26, 2'b00}`.

## Interface
- `ADDR_W`, 32: PC and memory address width; must be ≥ 28 + 2.
- `RESET_PC`, 0: PC value loaded at reset.
- `IBUF_DEPTH`, 4: instruction buffer entries; power of two, ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` out 1: fetch request valid.
- `req_ready` in 1: memory accepts the request.
- `req_addr` out ADDR_W: word-aligned fetch address.
- `rsp_valid` in 1: instruction returned; one cycle; no backpressure.
- `rsp_data` in 32: returned instruction word.
- `inst_valid` out 1: buffer head valid.
- `inst_ready` in 1: decode consumes the head.
- `inst` out 32: head instruction.
- `inst_pc4` out ADDR_W: head PC + 4.
- `redir_valid` in 1: redirect request; one-cycle pulse.
- `redir_sel` in 2: 00 branch, 01 jump, 10 register, 11 reserved (ignored).
- `redir_pc4` in ADDR_W: PC + 4 of the redirecting instruction.
- `redir_imm` in 26: branch offset in bits [15:0], or jump target.
- `redir_reg` in ADDR_W: register target for `jr`/`jalr`.
- `fetch_err` out 1: misaligned redirect target; only when `FETCH_ALIGN_CHECK_EN` is defined.

## Operation
- Redirect target:
  - Branch: `redir_pc4 + (sext(imm[15:0]) << 2)`.
  - Jump: `{redir_pc4[ADDR_W-1:28], imm, 2'b00}`.
  - Register: `redir_reg`.
- States:
  - IDLE: `req_valid` = 1 when the free entries exceed 0; `req_addr` = pc. On handshake, go to WAIT.
  - WAIT: on `rsp_valid`, push {rsp_data, pc+4}, set pc = pc+4, go to IDLE.
  - DRAIN: discard the outstanding response; on `rsp_valid`, go to IDLE.
  - HALT: only with `FETCH_ALIGN_CHECK_EN` defined. `req_valid` = 0; leave only by reset.
- At most one request is outstanding. Free-entry accounting includes the in-flight slot, so `rsp_valid` never meets a full buffer.
- Redirect, highest priority:
  - Load pc with the target and flush the buffer.
  - From WAIT or DRAIN, go to DRAIN.
  - From IDLE with a same-cycle handshake, go to DRAIN.
  - From IDLE without a handshake, stay IDLE.
  - From WAIT with a same-cycle `rsp_valid`, discard the response and go to IDLE.
- Redirect with a same-cycle pop: the buffer is flushed and the pop has no further effect.
- `redir_sel` = 11: the redirect is ignored entirely.
- Pop and push in the same cycle: count unchanged; pointers wrap modulo `IBUF_DEPTH`.

## Timing
- Reset (async assert, sync-safe release):
  - pc = `RESET_PC`, state IDLE, buffer empty.
  - `req_valid` = 0, `inst_valid` = 0, `fetch_err` = 0.
  - `req_valid` may rise in the first cycle after release.
- Minimum fetch interval: 2 cycles (handshake, then response). Zero-wait memory gives 1 instruction per 2 cycles.
- Latency: `rsp_valid` in cycle N gives `inst_valid` in cycle N+1 (registered FIFO).
- `inst_valid` is 0 in the cycle after a redirect.
- The first post-redirect request is issued:
  - in the cycle after the redirect when in IDLE;
  - in the cycle after the drained response otherwise.
- Reset mid-transaction discards all state. Memory side must drop an outstanding response on reset.
- `req_addr` and `req_valid` are stable while `req_valid` && !`req_ready`, except on redirect, which may retract the request.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A target with bits [1:0] != 0 is not loaded.
  - `fetch_err` goes to 1 (sticky) in the next cycle, the buffer is flushed, and state goes to HALT.
- Undefined:
  - Target bits [1:0] are forced to 00.
  - `fetch_err` is tied to 0.

## Structure
- `fetch_pkg` holds:
  - the state enum (IDLE, WAIT, DRAIN, HALT);
  - the `redir_sel` encodings (REDIR_BR, REDIR_J, REDIR_JR);
  - the `INST_W` = 32 constant.
- Sub-module `fetch_ibuf` is a parametrised synchronous FIFO (width `INST_W` + `ADDR_W`, depth `IBUF_DEPTH`) with:
  - a `flush` input;
  - a free-count output;
  - an active-low async reset.
- Next-PC and FSM logic stays in `mips_fetch_unit`.

## Test plan
- Reset release, `req_ready` = 1, 1-cycle response latency, `inst_ready` = 1 -> `req_addr` sequence 0, 4, 8, … every 2 cycles; `inst_pc4` = 4, 8, 12 …
- `inst_ready` = 0 with `IBUF_DEPTH` = 4 -> exactly 4 instructions buffered and `req_valid` = 0. One pop -> exactly one new request.
- Branch redirect, `redir_pc4` = 0x100, imm = 0xFFFE, arriving while in WAIT -> in-flight response discarded; next `req_addr` = 0xF8; no stale `inst_valid`.
- Jump, `redir_pc4` = 0x3000_0010, imm = 0x0000040 -> `req_addr` = 0x3000_0100. `jr` with `redir_reg` = 0x0040_0020 -> `req_addr` = 0x0040_0020.
- Redirect and `rsp_valid` in the same WAIT cycle, and redirect with a same-cycle pop -> response dropped, buffer empty, state IDLE next cycle.
- `FETCH_ALIGN_CHECK_EN`: `jr` to 0x0040_0022 -> `fetch_err` = 1, `req_valid` stays 0; rst low clears both. Undefined: fetch from 0x0040_0020.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS decoupled instruction-fetch stage.
package fetch_pkg;

  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    REDIR_BR   = 2'b00,
    REDIR_J    = 2'b01,
    REDIR_JR   = 2'b10,
    REDIR_NONE = 2'b11
  } redir_sel_e;

endpackage

// File: rtl/fetch_ibuf.sv
// Flushable synchronous FIFO holding fetched {instruction, pc+4} entries toward decode.
// Reports its free-entry count so the fetch FSM can reserve room before issuing.
module fetch_ibuf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] free_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign do_push = push && (count != DEPTH_C);
  assign do_pop  = pop && (count != '0);

  // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  // NOTE: state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign valid    = (count != '0);
  assign rdata    = mem[rd_ptr];
  assign free_cnt = DEPTH_C - count;

endmodule

// File: rtl/mips_fetch_unit.sv
// Decoupled MIPS fetch stage: owns the PC, keeps one request in flight, buffers returns.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned redirect targets (sticky fetch_err, HALT).
module mips_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                IBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              rsp_valid,
  input  logic [INST_W-1:0] rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc4,
  input  logic              redir_valid,
  input  logic [1:0]        redir_sel,
  input  logic [ADDR_W-1:0] redir_pc4,
  input  logic [25:0]       redir_imm,
  input  logic [ADDR_W-1:0] redir_reg,
  output logic              fetch_err
);

  localparam int CNT_W = $clog2(IBUF_DEPTH) + 1;
  localparam int ENT_W = INST_W + ADDR_W;

  fetch_state_e      state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, pc4;
  logic [ADDR_W-1:0] br_off, target_raw, target;
  logic              active, hs, push, flush, redir_fire, misalign;
  logic [CNT_W-1:0]  ibuf_free;
  logic [ENT_W-1:0]  ibuf_rdata;

  assign pc4    = pc + ADDR_W'(4);
  assign br_off = {{(ADDR_W-18){redir_imm[15]}}, redir_imm[15:0], 2'b00};

  always_comb begin
    target_raw = redir_reg;
    case (redir_sel_e'(redir_sel))
      REDIR_BR: target_raw = redir_pc4 + br_off;
      REDIR_J:  target_raw = {redir_pc4[ADDR_W-1:28], redir_imm, 2'b00};
      default:  target_raw = redir_reg;
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q;

  assign misalign = |target_raw[1:0];
  assign target   = target_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         err_q <= 1'b0;
    else if (redir_fire && misalign)  err_q <= 1'b1;
  end

  assign fetch_err = err_q;
`else
  assign misalign  = 1'b0;
  assign target    = target_raw & ~ADDR_W'(3);
  assign fetch_err = 1'b0;
`endif

  // Only IDLE issues, so the in-flight slot is always covered by the free count.
  assign req_valid  = active && (state == IDLE) && (ibuf_free != '0);
  assign req_addr   = pc;
  assign hs         = req_valid && req_ready;
  assign redir_fire = redir_valid && (redir_sel != REDIR_NONE) && (state != HALT);

  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    state_d = state;
    pc_d    = pc;
    push    = 1'b0;
    flush   = 1'b0;
    case (state)
      IDLE:  if (hs) state_d = WAIT;
      WAIT:  if (rsp_valid) begin
               push    = 1'b1;
               pc_d    = pc4;
               state_d = IDLE;
             end
      DRAIN: if (rsp_valid) state_d = IDLE;
      default: state_d = state;
    endcase
    // A redirect overrides everything; a response landing in the same cycle is dropped.
    if (redir_fire) begin
      push  = 1'b0;
      flush = 1'b1;
      if (misalign) begin
        state_d = HALT;
      end else begin
        pc_d = target;
        if (state == IDLE) state_d = hs ? DRAIN : IDLE;
        else               state_d = rsp_valid ? IDLE : DRAIN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      active <= 1'b0;
    end else begin
      state  <= state_d;
      pc     <= pc_d;
      active <= 1'b1;
    end
  end

  fetch_ibuf #(
    .WIDTH (ENT_W),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk      (clk),
    .rst_n    (rst),
    .flush    (flush),
    .push     (push),
    .wdata    ({rsp_data, pc4}),
    .pop      (inst_ready),
    .valid    (inst_valid),
    .rdata    (ibuf_rdata),
    .free_cnt (ibuf_free)
  );

  assign inst     = ibuf_rdata[ENT_W-1 -: INST_W];
  assign inst_pc4 = ibuf_rdata[ADDR_W-1:0];

endmodule
